alu_cmd_seq: RTL

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_cmd_seq.sv | 72 +++++++
 1 files changed

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: three-state sequencer that registers a command into an external ALU,
// captures its combinational result and hands it downstream, counting deliveries.
module alu_cmd_seq #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_sel,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_data;
  logic [1:0]       r_sel, r_res_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept, w_deliver;
  assign w_accept  = (r_state == IDLE) && cmd_valid;
  assign w_deliver = (r_state == DONE) && res_ready;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = cmd_valid ? EXEC : IDLE;
      EXEC:    w_next = DONE;
      DONE:    w_next = res_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sel     <= '0;
      r_data    <= '0;
      r_res_sel <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= cmd_a;
        r_b   <= cmd_b;
        r_sel <= cmd_sel;
      end
      if (r_state == EXEC) begin
        r_data    <= alu_z;
        r_res_sel <= r_sel;
      end
      if (w_deliver) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign cmd_ready = (r_state == IDLE);
  assign res_valid = (r_state == DONE);
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_sel;
  assign res_data  = r_data;
  assign res_sel   = r_res_sel;
  assign op_count  = r_cnt;
endmodule
